// File: rtl/unified_mem_arbiter.sv
// Arbiter for one single-ported memory shared by instruction fetch and MEM-stage load/store.
// Each access holds the address for LATENCY cycles, then returns a one-cycle ack.
module unified_mem_arbiter #(
    parameter int AW              = 32,
    parameter int DW              = 32,
    parameter int LATENCY         = 2,
    parameter int MAX_DATA_STREAK = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int            SW         = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [3:0]    LAT_C      = 4'(LATENCY);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          owner_q, owner_d;
    logic          store_q, store_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_ack_q, if_ack_d;
    logic          d_ack_q, d_ack_d;
    logic          busy_q, busy_d;
    logic          streak_full_s;
    logic          grant_fetch_s;

    assign streak_full_s = (MAX_DATA_STREAK != 0) && (streak_q == STREAK_MAX);
    assign grant_fetch_s = if_req & (~d_req | streak_full_s);

    // Next-state logic: arbitration, access sequencing and response capture
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        streak_d    = streak_q;
        owner_d     = owner_q;
        store_d     = store_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req | d_req) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = 4'd1;
                    mem_en_d = 1'b1;
                    if (grant_fetch_s) begin
                        owner_d    = 1'b0;
                        store_d    = 1'b0;
                        mem_addr_d = if_addr;
                        streak_d   = '0;
                    end else begin
                        owner_d     = 1'b1;
                        store_d     = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        // Streak only grows while fetch is actually waiting
                        if (if_req) begin
                            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
                        end else begin
                            streak_d = '0;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == LAT_C) begin
                    state_d  = ST_RESP;
                    mem_en_d = 1'b0;
                    if (owner_q) begin
                        d_ack_d = 1'b1;
                        if (!store_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                mem_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs; reset abandons any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            streak_q    <= '0;
            owner_q     <= 1'b0;
            store_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            streak_q    <= streak_d;
            owner_q     <= owner_d;
            store_q     <= store_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign d_stall   = d_req & ~d_ack_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized scoreboard bench for unified_mem_arbiter with a latency-accurate memory model.
module tb_unified_mem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXS = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_ack, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ack, d_stall;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we, busy, owner;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.AW(AW), .DW(DW), .LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [DW-1:0] dmem [int];
    logic [DW-1:0] gold [int];
    logic [DW-1:0] fexp [$];
    logic [DW-1:0] dexp [$];
    int            fiss [$];
    int            diss [$];
    bit            glog [$];
    logic [DW-1:0] last_load = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] imem_val(input logic [AW-1:0] a);
        if (a == 32'h0000_0010) return 32'h2008_000A;
        return a * 32'h9E37_79B1 + 32'h0000_1234;
    endfunction

    function automatic logic [DW-1:0] phys_read(input logic [AW-1:0] a);
        if (a >= 32'h40 && a < 32'h80) return dmem.exists(int'(a)) ? dmem[int'(a)] : 32'h0;
        return imem_val(a);
    endfunction

    function automatic int log_code();
        int code = 1;
        foreach (glog[i]) code = code * 2 + int'(glog[i]);
        return code;
    endfunction

    // Memory: data valid only in the LATENCY-th enabled cycle, noise otherwise
    int run = 0;
    always @(negedge clk) begin
        if (mem_en) run++; else run = 0;
        if (mem_en && mem_we) dmem[int'(mem_addr)] = mem_wdata;
        mem_rdata = (mem_en && run == LAT) ? phys_read(mem_addr) : DW'($urandom);
    end

    // Monitor: invariants every cycle, scoreboard pop on each ack
    bit mon_we_seen = 1'b0;
    always @(negedge clk) begin
        int lat;
        if (reset) begin
            check("one_ack", {63'd0, if_ack & d_ack}, 64'd0);
            check("if_stall", {63'd0, if_stall}, {63'd0, if_req & ~if_ack});
            check("d_stall", {63'd0, d_stall}, {63'd0, d_req & ~d_ack});
            if (mem_en | if_ack | d_ack) check("busy", {63'd0, busy}, 64'd1);
            if (!mem_en) mon_we_seen = 1'b0;
            if (mem_we) begin
                check("we_once", {63'd0, mon_we_seen}, 64'd0);
                mon_we_seen = 1'b1;
                check("we_src", {61'd0, owner, d_req, d_we}, 64'd7);
                check("we_addr", {32'd0, mem_addr}, {32'd0, d_addr});
                check("we_data", {32'd0, mem_wdata}, {32'd0, d_wdata});
            end
            if (if_ack) begin
                tests++;
                if (fexp.size() == 0) begin
                    fails++;
                    $display("FAIL if_ack_unexpected: got if_ack=1 expected no fetch pending (cycle %0d)", cyc);
                end else begin
                    tests--;
                    check("if_rdata", {32'd0, if_rdata}, {32'd0, fexp.pop_front()});
                    check("if_owner", {63'd0, owner}, 64'd0);
                    lat = cyc - fiss.pop_front();
                    check("if_lat_min", {63'd0, lat >= LAT + 1}, 64'd1);
                    check("if_lat_max", {63'd0, lat <= 2 * LAT + 2 + MAXS * (LAT + 2)}, 64'd1);
                    glog.push_back(1'b0);
                end
            end
            if (d_ack) begin
                tests++;
                if (dexp.size() == 0) begin
                    fails++;
                    $display("FAIL d_ack_unexpected: got d_ack=1 expected no data pending (cycle %0d)", cyc);
                end else begin
                    tests--;
                    check("d_rdata", {32'd0, d_rdata}, {32'd0, dexp.pop_front()});
                    check("d_owner", {63'd0, owner}, 64'd1);
                    lat = cyc - diss.pop_front();
                    check("d_lat_min", {63'd0, lat >= LAT + 1}, 64'd1);
                    check("d_lat_max", {63'd0, lat <= 3 * LAT + 4}, 64'd1);
                    glog.push_back(1'b1);
                end
            end
        end
    end

    task automatic fetch_req(input logic [AW-1:0] a, output int lat);
        bit got = 1'b0;
        int c0  = cyc;
        if_addr = a;
        if_req  = 1'b1;
        fexp.push_back(imem_val(a));
        fiss.push_back(cyc);
        lat = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (if_ack) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL fetch_timeout: got no if_ack for addr %0h expected one within 200 cycles", a);
        end
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        if_addr = AW'($urandom);
    endtask

    task automatic data_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, output int lat);
        bit got = 1'b0;
        int c0  = cyc;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        if (we) begin
            gold[int'(a)] = wd;
            dexp.push_back(last_load);
        end else begin
            last_load = gold.exists(int'(a)) ? gold[int'(a)] : 32'h0;
            dexp.push_back(last_load);
        end
        diss.push_back(cyc);
        lat = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (d_ack) begin
                got = 1'b1;
                lat = cyc - c0;
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL data_timeout: got no d_ack for addr %0h expected one within 200 cycles", a);
        end
        @(posedge clk);
        #1;
        d_req   = 1'b0;
        d_we    = 1'($urandom);
        d_addr  = AW'($urandom);
        d_wdata = DW'($urandom);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctrl"}, {58'd0, if_ack, d_ack, mem_en, mem_we, busy, owner}, 64'd0);
        check({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
        check({tag, "_mem"}, {mem_addr, mem_wdata}, 64'd0);
    endtask

    initial begin
        int lf, ld, l1, l2;
        bit seen;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        check("reset_stalls", {62'd0, if_stall, d_stall}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Lone fetch, lone store, load-back of the stored word
        fetch_req(32'h10, lf);
        check("fetch_lat", 64'(lf), 64'(LAT + 1));
        data_req(1'b1, 32'h40, 32'hDEAD_BEEF, ld);
        check("store_lat", 64'(ld), 64'(LAT + 1));
        check("store_mem", {32'd0, phys_read(32'h40)}, 64'hDEAD_BEEF);
        data_req(1'b0, 32'h40, 32'h0, ld);

        // Simultaneous requests: data first, fetch on the following grant
        glog.delete();
        fork
            fetch_req(32'h20, lf);
            data_req(1'b0, 32'h44, 32'h0, ld);
        join
        check("cont_order", 64'(log_code()), 64'b110);
        check("cont_d_lat", 64'(ld), 64'(LAT + 1));
        check("cont_f_lat", 64'(lf), 64'(2 * (LAT + 2) - 1));

        // Starvation guard: fetch forced after MAXS consecutive data grants
        glog.delete();
        fork
            begin repeat (2) fetch_req(AW'($urandom_range(0, 63)), l1); end
            begin repeat (4) data_req(1'b0, AW'(32'h40 + $urandom_range(0, 15)), 32'h0, l2); end
        join
        check("streak_order", 64'(log_code()), 64'b1110110);

        // Reset during the first access cycle of a store
        d_we = 1'b1; d_addr = 32'h70; d_wdata = DW'($urandom); d_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_en) seen = 1'b1;
        end
        check("rst_reached_access", {63'd0, seen}, 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check_outputs_zero("midrst");
        d_req = 1'b0;
        last_load = '0;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_no_we", {63'd0, mem_we}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        fetch_req(32'h24, lf);
        check("post_rst_lat", 64'(lf), 64'(LAT + 1));

        // Randomized concurrent traffic
        fork
            begin
                int l;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    fetch_req(AW'($urandom_range(0, 63)), l);
                end
            end
            begin
                int l;
                for (int i = 0; i < 30; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    data_req(1'($urandom), AW'(32'h40 + $urandom_range(0, 15)), DW'($urandom), l);
                end
            end
        join
        repeat (2) @(posedge clk);
        check("fexp_drained", 64'(fexp.size()), 64'd0);
        check("dexp_drained", 64'(dexp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        fails++;
        $display("FAIL watchdog: got simulation still running expected completion before 500000 time units");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
